// File: rtl/parking_lane_monitor.sv
// Multi-lane parking gate monitor: per-lane sensor debounce and direction FSM,
// with a shared clamped occupancy counter and full/empty status.
module parking_lane_monitor #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned CAPACITY = 100,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*LANES-1:0] sensor,
  output logic [LANES-1:0]   entrada,
  output logic [LANES-1:0]   salida,
  output logic [LANES-1:0]   error,
  output logic [CNT_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned DbW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned SumW = CNT_W + $clog2(LANES) + 1;
  localparam logic [DbW-1:0]         DbLast = DbW'(DEBOUNCE - 1);
  localparam logic signed [SumW-1:0] CapS   = SumW'(CAPACITY);
  localparam logic [CNT_W-1:0]       CapU   = CNT_W'(CAPACITY);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StEn1  = 3'd1;
  localparam logic [2:0] StEn2  = 3'd2;
  localparam logic [2:0] StEn3  = 3'd3;
  localparam logic [2:0] StEx1  = 3'd4;
  localparam logic [2:0] StEx2  = 3'd5;
  localparam logic [2:0] StEx3  = 3'd6;
  localparam logic [2:0] StWait = 3'd7;

  logic [LANES-1:0] ent_ev, ext_ev, err_ev;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [1:0]     raw, cand_q, d_q;
    logic [DbW-1:0] cnt_q;
    logic [2:0]     st_q, st_d;
    logic           ent, ext, err;

    assign raw = sensor[2*i +: 2];

    always_ff @(posedge clk) begin
      if (reset) begin
        cand_q <= 2'b00;
        d_q    <= 2'b00;
        cnt_q  <= '0;
        st_q   <= StIdle;
      end else begin
        if (raw != cand_q) begin
          cand_q <= raw;
          cnt_q  <= '0;
        end else if (cnt_q == DbLast) begin
          d_q <= cand_q;
        end else begin
          cnt_q <= cnt_q + DbW'(1);
        end
        st_q <= st_d;
      end
    end

    // Entry walks 10 -> 11 -> 01 -> 00; exit is the mirror image.
    always_comb begin
      st_d = st_q;
      ent  = 1'b0;
      ext  = 1'b0;
      err  = 1'b0;
      case (st_q)
        StIdle: case (d_q)
          2'b10:   st_d = StEn1;
          2'b01:   st_d = StEx1;
          2'b11:   begin st_d = StWait; err = 1'b1; end
          default: ;
        endcase
        StEn1: case (d_q)
          2'b11:   st_d = StEn2;
          2'b00:   st_d = StIdle;
          2'b01:   begin st_d = StWait; err = 1'b1; end
          default: ;
        endcase
        StEn2: case (d_q)
          2'b01:   st_d = StEn3;
          2'b10:   st_d = StEn1;
          2'b00:   begin st_d = StWait; err = 1'b1; end
          default: ;
        endcase
        StEn3: case (d_q)
          2'b00:   begin st_d = StIdle; ent = 1'b1; end
          2'b11:   st_d = StEn2;
          2'b10:   begin st_d = StWait; err = 1'b1; end
          default: ;
        endcase
        StEx1: case (d_q)
          2'b11:   st_d = StEx2;
          2'b00:   st_d = StIdle;
          2'b10:   begin st_d = StWait; err = 1'b1; end
          default: ;
        endcase
        StEx2: case (d_q)
          2'b10:   st_d = StEx3;
          2'b01:   st_d = StEx1;
          2'b00:   begin st_d = StWait; err = 1'b1; end
          default: ;
        endcase
        StEx3: case (d_q)
          2'b00:   begin st_d = StIdle; ext = 1'b1; end
          2'b11:   st_d = StEx2;
          2'b01:   begin st_d = StWait; err = 1'b1; end
          default: ;
        endcase
        default: if (d_q == 2'b00) st_d = StIdle;
      endcase
    end

    assign ent_ev[i] = ent;
    assign ext_ev[i] = ext;
    assign err_ev[i] = err;
  end

  logic signed [SumW-1:0] sum;
  logic [CNT_W-1:0]       occ_d;
  logic                   ovf_d, unf_d;

  always_comb begin
    sum = $signed(SumW'(occupancy));
    for (int i = 0; i < LANES; i++) begin
      sum = sum + $signed(SumW'(ent_ev[i])) - $signed(SumW'(ext_ev[i]));
    end
  end

  always_comb begin
    occ_d = sum[CNT_W-1:0];
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (sum[SumW-1]) begin
      occ_d = '0;
      unf_d = 1'b1;
    end else if (sum > CapS) begin
      occ_d = CapU;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entrada   <= '0;
      salida    <= '0;
      error     <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      entrada   <= ent_ev;
      salida    <= ext_ev;
      error     <= err_ev;
      occupancy <= occ_d;
      full      <= (occ_d == CapU);
      empty     <= (occ_d == '0);
      overflow  <= ovf_d;
      underflow <= unf_d;
    end
  end

endmodule

// File: tb/tb_parking_lane_monitor.sv
// Directed scoreboard bench for parking_lane_monitor (2 lanes, capacity 8).
module tb_parking_lane_monitor;

  localparam int unsigned Lanes = 2;
  localparam int unsigned Cap   = 8;
  localparam int unsigned CntW  = 8;
  localparam int unsigned Deb   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      sensor;
  logic [1:0]      entrada, salida, error;
  logic [CntW-1:0] occupancy;
  logic            full, empty, overflow, underflow;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] at;
    logic [1:0]  ent, sal, err;
    logic [7:0]  occ;
    logic        full, empty, ovf, unf;
  } exp_t;

  exp_t exp_q[$];

  parking_lane_monitor #(
    .LANES(Lanes), .CAPACITY(Cap), .CNT_W(CntW), .DEBOUNCE(Deb)
  ) dut (
    .clk(clk), .reset(reset), .sensor(sensor),
    .entrada(entrada), .salida(salida), .error(error),
    .occupancy(occupancy), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: any pulse output means the DUT presented an event.
  always @(negedge clk) begin
    if (reset === 1'b0 && (|{entrada, salida, error, overflow, underflow}) === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event at cycle %0d: ent=%b sal=%b err=%b ovf=%b unf=%b, expected none",
                 cyc, entrada, salida, error, overflow, underflow);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_cycle", cyc,       e.at);
        chk("entrada",     entrada,   e.ent);
        chk("salida",      salida,    e.sal);
        chk("error",       error,     e.err);
        chk("occupancy",   occupancy, e.occ);
        chk("full",        full,      e.full);
        chk("empty",       empty,     e.empty);
        chk("overflow",    overflow,  e.ovf);
        chk("underflow",   underflow, e.unf);
      end
    end
  end

  task automatic hold(input logic [3:0] s, input int n);
    sensor = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold3(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2);
    hold(v0, 6);
    hold(v1, 6);
    hold(v2, 6);
  endtask

  // Raw change seen at edge 0; the resulting pulse is registered at edge Deb+1.
  task automatic expect_ev(input logic [3:0] s, input int n,
                           input logic [1:0] ent, input logic [1:0] sal, input logic [1:0] err,
                           input logic [7:0] occ, input logic f, input logic e,
                           input logic o, input logic u);
    exp_t x;
    x.at = cyc + Deb + 2;
    x.ent = ent; x.sal = sal; x.err = err; x.occ = occ;
    x.full = f; x.empty = e; x.ovf = o; x.unf = u;
    exp_q.push_back(x);
    hold(s, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    sensor = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_occupancy", occupancy, 0);
    chk("reset_empty",     empty,     1);
    chk("reset_full",      full,      0);
    chk("reset_pulses",    {entrada, salida, error, overflow, underflow}, 0);
    reset = 1'b0;

    // Lane 0 entry.
    hold3(4'b0010, 4'b0011, 4'b0001);
    expect_ev(4'b0000, 8, 2'b01, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Short glitches (3 and Deb cycles) never reach the FSM; then an aborted entry.
    hold(4'b0010, 3);
    hold(4'b0000, 8);
    hold(4'b0011, Deb);
    hold(4'b0000, 8);
    hold(4'b0010, 6);
    hold(4'b0000, 8);
    chk("abort_occupancy", occupancy, 1);
    chk("abort_empty",     empty,     0);

    // Lane 1 entries up to 3.
    hold3(4'b1000, 4'b1100, 4'b0100);
    expect_ev(4'b0000, 8, 2'b10, 2'b00, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    hold3(4'b1000, 4'b1100, 4'b0100);
    expect_ev(4'b0000, 8, 2'b10, 2'b00, 2'b00, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Lane 0 entry and lane 1 exit on the same edge.
    hold3(4'b0110, 4'b1111, 4'b1001);
    expect_ev(4'b0000, 8, 2'b01, 2'b10, 2'b00, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Dual entries to 7.
    hold3(4'b1010, 4'b1111, 4'b0101);
    expect_ev(4'b0000, 8, 2'b11, 2'b00, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    hold3(4'b1010, 4'b1111, 4'b0101);
    expect_ev(4'b0000, 8, 2'b11, 2'b00, 2'b00, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with lane 0 in EN2; the rest of the passage must not count.
    hold(4'b0010, 6);
    hold(4'b0011, 6);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_occupancy", occupancy, 0);
    chk("midreset_empty",     empty,     1);
    chk("midreset_full",      full,      0);
    chk("midreset_pulses",    {entrada, salida, error, overflow, underflow}, 0);
    reset = 1'b0;
    hold(4'b0001, 6);
    hold(4'b0000, 8);
    chk("postreset_occupancy", occupancy, 0);

    // Exit at zero clamps.
    hold3(4'b0100, 4'b1100, 4'b1000);
    expect_ev(4'b0000, 8, 2'b00, 2'b10, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Fill to 7, then two entries clamp at capacity.
    hold3(4'b1010, 4'b1111, 4'b0101);
    expect_ev(4'b0000, 8, 2'b11, 2'b00, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    hold3(4'b1010, 4'b1111, 4'b0101);
    expect_ev(4'b0000, 8, 2'b11, 2'b00, 2'b00, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    hold3(4'b1010, 4'b1111, 4'b0101);
    expect_ev(4'b0000, 8, 2'b11, 2'b00, 2'b00, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    hold3(4'b0010, 4'b0011, 4'b0001);
    expect_ev(4'b0000, 8, 2'b01, 2'b00, 2'b00, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    hold3(4'b1010, 4'b1111, 4'b0101);
    expect_ev(4'b0000, 8, 2'b11, 2'b00, 2'b00, 8'd8, 1'b1, 1'b0, 1'b1, 1'b0);

    // Lane 1 illegal jump 00 -> 11, then 01 -> 00 gives no exit.
    expect_ev(4'b1100, 6, 2'b00, 2'b00, 2'b10, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    hold(4'b0100, 6);
    hold(4'b0000, 8);
    chk("illegal_occupancy", occupancy, 8);

    // Lane 1 is back in IDLE: a clean exit counts.
    hold3(4'b0100, 4'b1100, 4'b1000);
    expect_ev(4'b0000, 8, 2'b00, 2'b10, 2'b00, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_lane_monitor.md
# parking_lane_monitor

Multi-lane parking access monitor. Each of `LANES` gates has a two-beam sensor pair {a, b}. Every lane debounces its raw sensors, tracks passage direction with its own state machine, and emits one-cycle entry and exit pulses. A shared occupancy counter adds all lanes' events each cycle, clamps the count to `[0, CAPACITY]`, and drives full/empty status for the lot's sign and barrier logic.

## Interface
- `LANES`, default 2: number of independent gate lanes (≥1).
- `CAPACITY`, default 100: maximum occupancy (≥1; must be < 2^`CNT_W`).
- `CNT_W`, default 8: occupancy counter width.
- `DEBOUNCE`, default 4: consecutive cycles a raw value must hold before it is accepted (≥1).

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `sensor`  in  2*LANES  raw sensors; lane i is `sensor[2i+1:2i]` = {a, b}, 1 = beam broken.
- `entrada`  out  LANES  one-cycle pulse per completed entry, per lane.
- `salida`  out  LANES  one-cycle pulse per completed exit, per lane.
- `error`  out  LANES  one-cycle pulse on an illegal sensor jump, per lane.
- `occupancy`  out  CNT_W  current vehicle count.
- `full`  out  1  `occupancy == CAPACITY`.
- `empty`  out  1  `occupancy == 0`.
- `overflow`  out  1  one-cycle pulse when an update clamps at `CAPACITY`.
- `underflow`  out  1  one-cycle pulse when an update clamps at 0.

## Operation
- **Reset** (synchronous): every lane sets candidate = 00, debounced value d = 00, debounce counter = 0, state = IDLE. All pulse outputs = 0, `occupancy` = 0, `empty` = 1, `full` = 0.
- **Debounce, per lane:**
  - If raw ≠ candidate: candidate ← raw, counter ← 0.
  - Else if counter == `DEBOUNCE`-1: d ← candidate.
  - Else: counter ← counter+1.
- **Lane FSM** (runs on d, one transition per cycle). States: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT.
  - IDLE: 10→EN1; 01→EX1; 11→WAIT with error pulse; 00 stays.
  - EN1 (10): 11→EN2; 00→IDLE, no event; 01→WAIT with error pulse.
  - EN2 (11): 01→EN3; 10→EN1 (backing out); 00→WAIT with error pulse.
  - EN3 (01): 00→IDLE and pulse `entrada[i]`; 11→EN2; 10→WAIT with error pulse.
  - EX1, EX2, EX3 mirror EN1–EN3 with a and b swapped. EX3 (10) → IDLE on 00 and pulses `salida[i]`.
  - WAIT: stays until d == 00, then → IDLE. Produces no further pulses.
  - An unchanged d keeps the current state.
- **Occupancy:**
  - E = popcount of this cycle's entry events; X = popcount of exit events. Sum in CNT_W+$clog2(LANES)+1 signed bits: next = occupancy + E − X.
  - next > `CAPACITY` → `occupancy` = `CAPACITY`, `overflow` pulse.
  - next < 0 → `occupancy` = 0, `underflow` pulse.
  - Lane `entrada`/`salida` pulses are emitted even when the count clamps.
- `full` and `empty` are registered and always consistent with the registered `occupancy`.

## Timing
- The raw value first appears before edge 0 and holds. d updates at edge `DEBOUNCE`.
- The FSM reacts at edge `DEBOUNCE`+1. At that same edge, the `entrada`/`salida`/`error` pulse, the new `occupancy`, `full`/`empty`, and any `overflow`/`underflow` are all registered.
- End-to-end latency from the final raw 00 to `entrada` high: `DEBOUNCE`+1 cycles.
- A raw glitch shorter than `DEBOUNCE`+1 cycles never reaches d.
- All pulses last exactly one cycle. One completed passage produces exactly one pulse.
- Lanes are fully independent. Any mix of simultaneous lane events is summed within a single cycle.
- Reset mid-sequence discards partial passages. No pulse is emitted for a discarded passage, and the count returns to 0.

## Test plan
- **Entry:** `DEBOUNCE`=4; lane 0 raw 00→10→11→01→00, each held 6 cycles → `entrada[0]` pulses once, exactly 5 cycles after the final 00; `occupancy` 0→1; `empty` falls in the same cycle.
- **Glitch and abort:** lane 0 at 00 gets a 3-cycle raw 10 glitch → no state change. Then 10 held, followed by 00 → back to IDLE, no pulse, `occupancy` unchanged.
- **Simultaneous lanes:** `occupancy`=3; lane 0 entry and lane 1 exit complete on the same edge → both pulse, `occupancy` stays 3.
- **Clamping:** `CAPACITY`=4, `occupancy`=3, two simultaneous entries → `occupancy`=4, `full`=1, `overflow` pulses. With `occupancy`=0, an exit → `salida` pulses, `underflow` pulses, `occupancy` stays 0.
- **Illegal jump:** lane 1 d goes 00→11 → `error[1]` pulses once. Then 01→00 → no `salida`, and the lane returns to IDLE.
- **Reset mid-operation:** assert `reset` while lane 0 is in EN2 with `occupancy`=7 → next cycle all outputs at reset values. Completing the remaining raw sequence produces no `entrada`.
